// File: rtl/dvp_pkg.sv
// Shared definitions for the video packer; the error bit positions are also
// used by the CSI status register.
package dvp_pkg;

  localparam int DEF_WDT = 640;
  localparam int DEF_HGT = 480;
  localparam int CNT_W   = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } pack_state_t;

  localparam int ERR_SHORT_BIT = 0;
  localparam int ERR_LONG_BIT  = 1;
  localparam int ERR_FRAME_BIT = 2;
  localparam int ERR_W         = 3;

  // Saturate so an absurdly long line cannot wrap and re-trigger err_long.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register slice carrying data, tuser and tlast.
module axis_reg_slice #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tuser,
  input  logic          s_tlast,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tuser,
  output logic          m_tlast
);

  assign s_tready = !m_tvalid || m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (s_tready) begin
      m_tvalid <= s_tvalid;
      if (s_tvalid) begin
        m_tdata <= s_tdata;
        m_tuser <= s_tuser;
        m_tlast <= s_tlast;
      end
    end
  end

endmodule

// File: rtl/vid_pack.sv
// Packs two 16-bit CSI pixels per 32-bit word, tracks line/frame geometry and
// raises sticky geometry error flags.
module vid_pack
  import dvp_pkg::*;
#(
  parameter int WDT = DEF_WDT,
  parameter int HGT = DEF_HGT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic        err_clr,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [15:0] s_tdata,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] m_tdata,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        err_short,
  output logic        err_long,
  output logic        err_frame,
  output logic        frame_done,
  output logic [11:0] line_cnt
);

  localparam logic [CNT_W-1:0] WDT_C    = CNT_W'(WDT);
  localparam logic [CNT_W-1:0] HGT_LAST = CNT_W'(HGT - 1);

  pack_state_t      state_reg;
  logic [15:0]      lo_reg;
  logic             sof_reg;
  logic [CNT_W-1:0] pix_reg;
  logic [CNT_W-1:0] line_reg;
  logic             done_reg;
  logic [ERR_W-1:0] err_reg;
  logic [ERR_W-1:0] err_next;
  logic [ERR_W-1:0] err_set;

  logic             slice_ready;
  logic             take;
  logic             lo_role;
  logic [CNT_W-1:0] pix_next;
  logic [CNT_W-1:0] line_base;
  logic             push;
  logic [31:0]      push_data;
  logic             push_user;
  logic             push_last;

  // A one-pixel line arriving in IDLE would need the output register at once,
  // so that single case waits for room instead of being dropped.
  always_comb begin
    s_tready = 1'b1;
    if (enb) begin
      if (state_reg == ST_IDLE) s_tready = !(s_tuser && s_tlast && !slice_ready);
      else                      s_tready = slice_ready;
    end
  end

  assign take      = s_tvalid && s_tready && enb && (state_reg != ST_IDLE || s_tuser);
  assign lo_role   = s_tuser || (state_reg == ST_LO);
  assign line_base = s_tuser ? '0 : line_reg;
  assign pix_next  = sat_inc(s_tuser ? '0 : pix_reg);

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_user = 1'b0;
    push_last = 1'b0;
    if (take) begin
      if (!lo_role) begin
        push      = 1'b1;
        push_data = {s_tdata, lo_reg};
        push_user = sof_reg;
        push_last = s_tlast;
      end else if (s_tlast) begin
        push      = 1'b1;
        push_data = {16'h0000, s_tdata};
        push_user = s_tuser;
        push_last = 1'b1;
      end
    end
  end

  always_comb begin
    err_set                = '0;
    err_set[ERR_SHORT_BIT] = take && s_tlast && (pix_next < WDT_C);
    err_set[ERR_LONG_BIT]  = take && !s_tlast && (pix_next == WDT_C);
    err_set[ERR_FRAME_BIT] = take && s_tuser && (state_reg != ST_IDLE);
  end

  // A set in the same cycle as err_clr wins.
  generate
    for (genvar gi = 0; gi < ERR_W; gi++) begin : g_err
      assign err_next[gi] = (err_reg[gi] && !err_clr) || err_set[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) err_reg <= '0;
    else     err_reg <= err_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      lo_reg    <= '0;
      sof_reg   <= 1'b0;
      pix_reg   <= '0;
      line_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (!enb) begin
        state_reg <= ST_IDLE;
        sof_reg   <= 1'b0;
        pix_reg   <= '0;
      end else if (take) begin
        if (s_tlast) begin
          pix_reg  <= '0;
          line_reg <= line_base + CNT_W'(1);
          if (line_base == HGT_LAST) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_LO;
          end
        end else begin
          pix_reg  <= pix_next;
          line_reg <= line_base;
          if (lo_role) begin
            lo_reg    <= s_tdata;
            sof_reg   <= s_tuser;
            state_reg <= ST_HI;
          end else begin
            state_reg <= ST_LO;
          end
        end
      end
    end
  end

  axis_reg_slice #(.DW(32)) u_out (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (push),
    .s_tready (slice_ready),
    .s_tdata  (push_data),
    .s_tuser  (push_user),
    .s_tlast  (push_last),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast)
  );

  assign err_short  = err_reg[ERR_SHORT_BIT];
  assign err_long   = err_reg[ERR_LONG_BIT];
  assign err_frame  = err_reg[ERR_FRAME_BIT];
  assign frame_done = done_reg;
  assign line_cnt   = line_reg;

endmodule
